// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request path.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS);

  typedef enum logic [1:0] {
    StIdle,
    StDispatch,
    StDoorOpen,
    StHalted
  } state_e;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] idx);
    floor_onehot      = '0;
    floor_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One floor button: 2-flop synchronizer, saturating stable-high counter and a
// single-cycle press strobe on the cycle the counter reaches its threshold.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      if (!sync2_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Strobe on the edge where the counter steps into saturation, so it fires once per press.
  assign press = sync2_q && (cnt_q == CntMax - 1'b1);

endmodule

// File: rtl/floor_call_dispatcher.sv
// Latches debounced floor calls, dispatches them one at a time in SCAN order to the
// motion controller, and runs the door dwell on arrival.
module floor_call_dispatcher
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic                  emergency_stop,
  input  logic                  move_up,
  input  logic                  move_down,
  input  logic                  motor_stop,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] floor_req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  serviced_valid,
  output logic [FLOOR_W-1:0]    serviced_floor
);

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DwellW-1:0] DwellMax = DwellW'(DWELL_CYCLES - 1);

  state_e                state_q;
  logic                  dir_up_q, fault_q;
  logic [FLOOR_W-1:0]    target_q;
  logic [NUM_FLOORS-1:0] pending_q;
  logic [DwellW-1:0]     dwell_q;

  logic [NUM_FLOORS-1:0] press;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .btn    (btn[g]),
      .press  (press[g])
    );
  end

  logic [NUM_FLOORS-1:0] cur_oh, cand, absorb, clr;
  logic                  cur_pending, cur_press, arrive, ctrl_moving;
  logic                  have_above, have_below, sel_valid, sel_dir_up;
  logic [FLOOR_W-1:0]    near_above, near_below, sel_floor;

  always_comb begin
    cur_oh      = floor_onehot(current_floor);
    cand        = pending_q & ~cur_oh;
    cur_pending = |(pending_q & cur_oh);
    cur_press   = |(press & cur_oh);
    ctrl_moving = move_up || move_down;
    arrive      = (state_q == StDispatch) && (current_floor == target_q) && motor_stop &&
                  !emergency_stop;

    // Descending scan keeps the lowest candidate above, ascending the highest below.
    have_above = 1'b0;
    near_above = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (cand[i] && i > int'(current_floor)) begin
        have_above = 1'b1;
        near_above = FLOOR_W'(i);
      end
    end
    have_below = 1'b0;
    near_below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (cand[i] && i < int'(current_floor)) begin
        have_below = 1'b1;
        near_below = FLOOR_W'(i);
      end
    end

    sel_valid = have_above || have_below;
    if (dir_up_q) begin
      sel_dir_up = have_above;
      sel_floor  = have_above ? near_above : near_below;
    end else begin
      sel_dir_up = !have_below;
      sel_floor  = have_below ? near_below : near_above;
    end

    // A same-floor press opens or extends the door instead of becoming a call.
    absorb = '0;
    if (!emergency_stop &&
        ((state_q == StIdle && motor_stop) || (state_q == StDoorOpen && !ctrl_moving))) begin
      absorb = cur_oh;
    end

    clr = '0;
    if (state_q == StIdle && !emergency_stop && motor_stop && cur_pending) begin
      clr = cur_oh;
    end else if (arrive) begin
      clr = floor_onehot(target_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      dir_up_q       <= 1'b1;
      fault_q        <= 1'b0;
      target_q       <= '0;
      pending_q      <= '0;
      dwell_q        <= '0;
      floor_req      <= '0;
      door_open      <= 1'b0;
      serviced_valid <= 1'b0;
      serviced_floor <= '0;
    end else begin
      serviced_valid <= 1'b0;
      pending_q      <= (pending_q | (press & ~absorb)) & ~clr;
      if (emergency_stop) begin
        state_q   <= StHalted;
        floor_req <= '0;
        door_open <= 1'b0;
        dwell_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (motor_stop && (cur_pending || cur_press)) begin
              state_q   <= StDoorOpen;
              door_open <= 1'b1;
              dwell_q   <= DwellMax;
              if (cur_pending) begin
                serviced_valid <= 1'b1;
                serviced_floor <= current_floor;
              end
            end else if (sel_valid) begin
              state_q   <= StDispatch;
              target_q  <= sel_floor;
              dir_up_q  <= sel_dir_up;
              floor_req <= floor_onehot(sel_floor);
            end
          end
          StDispatch: begin
            if (arrive) begin
              state_q        <= StDoorOpen;
              floor_req      <= '0;
              door_open      <= 1'b1;
              dwell_q        <= DwellMax;
              serviced_valid <= 1'b1;
              serviced_floor <= target_q;
            end
          end
          StDoorOpen: begin
            if (ctrl_moving) begin
              // Controller moving with the door open: hold off until it goes quiet.
              state_q   <= StHalted;
              fault_q   <= 1'b1;
              door_open <= 1'b0;
              dwell_q   <= '0;
            end else if (cur_press) begin
              dwell_q <= DwellMax;
            end else if (dwell_q == '0) begin
              state_q   <= StIdle;
              door_open <= 1'b0;
            end else begin
              dwell_q <= dwell_q - 1'b1;
            end
          end
          StHalted: begin
            if (!fault_q || !ctrl_moving) begin
              state_q <= StIdle;
              fault_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_floor_call_dispatcher.sv
// Scoreboarded bench: directed scenarios plus randomized call batches checked against a
// set-based SCAN service-order model.
module tb_floor_call_dispatcher;
  import elevator_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_FLOORS-1:0] btn;
  logic                  emergency_stop, move_up, move_down, motor_stop;
  logic [FLOOR_W-1:0]    current_floor;
  logic [NUM_FLOORS-1:0] floor_req, pending;
  logic                  door_open, serviced_valid;
  logic [FLOOR_W-1:0]    serviced_floor;

  int checks = 0;
  int failures = 0;
  int sb[$];
  bit auto_ctrl = 1'b0;
  bit model_up;

  always #5 clk = ~clk;

  floor_call_dispatcher #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES   (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn           (btn),
    .emergency_stop(emergency_stop),
    .move_up       (move_up),
    .move_down     (move_down),
    .motor_stop    (motor_stop),
    .current_floor (current_floor),
    .floor_req     (floor_req),
    .pending       (pending),
    .door_open     (door_open),
    .serviced_valid(serviced_valid),
    .serviced_floor(serviced_floor)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Simple controller: one floor per cycle toward floor_req, stopped otherwise.
  task automatic ctrl_step();
    int tgt;
    tgt = -1;
    for (int i = 0; i < NUM_FLOORS; i++) if (floor_req[i]) tgt = i;
    if (tgt < 0) begin
      motor_stop = 1'b1;
      move_up    = 1'b0;
      move_down  = 1'b0;
    end else begin
      if (int'(current_floor) < tgt) current_floor = current_floor + 1'b1;
      else if (int'(current_floor) > tgt) current_floor = current_floor - 1'b1;
      motor_stop = (int'(current_floor) == tgt);
      move_up    = (int'(current_floor) < tgt);
      move_down  = (int'(current_floor) > tgt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ctrl) ctrl_step();
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (door_open === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  // Service order for a set of calls: keep going the current way, else turn around.
  task automatic push_scan(input logic [NUM_FLOORS-1:0] calls, input int start, inout bit up);
    int cur, above, below, t;
    logic [NUM_FLOORS-1:0] s;
    cur = start;
    s   = calls;
    while (s != '0) begin
      above = -1;
      below = -1;
      for (int i = cur + 1; i < NUM_FLOORS; i++) if (s[i] && above < 0) above = i;
      for (int i = cur - 1; i >= 0; i--) if (s[i] && below < 0) below = i;
      if (up) begin
        if (above >= 0) t = above;
        else begin t = below; up = 1'b0; end
      end else begin
        if (below >= 0) t = below;
        else begin t = above; up = 1'b1; end
      end
      sb.push_back(t);
      s[t] = 1'b0;
      cur  = t;
    end
  endtask

  // Monitor: every serviced pulse must match the head of the expected queue.
  initial begin
    int exp;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && serviced_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL serviced_unexpected: got floor %0d expected no service", serviced_floor);
        end else begin
          exp = sb.pop_front();
          check("serviced_floor", 32'(serviced_floor), 32'(exp));
        end
      end
    end
  end

  initial begin
    int n;
    logic [NUM_FLOORS-1:0] acc, calls;

    reset_n = 1'b0; btn = '0; emergency_stop = 1'b0;
    move_up = 1'b0; move_down = 1'b0; motor_stop = 1'b1; current_floor = '0;
    #2;
    check("rst_floor_req", 32'(floor_req), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_door", 32'(door_open), 0);
    check("rst_serviced", 32'({serviced_valid, serviced_floor}), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Single call to floor 2 from floor 0
    btn[2] = 1'b1;
    repeat (5) tick();
    check("single_pending_e5", 32'(pending), 0);
    tick();
    check("single_pending_e6", 32'(pending), 32'b0100);
    check("single_req_e6", 32'(floor_req), 0);
    tick();
    check("single_req_e7", 32'(floor_req), 32'b0100);
    tick();
    btn = '0;
    sb.push_back(2);
    current_floor = 2;
    tick();
    check("single_req_cleared", 32'(floor_req), 0);
    check("single_pending_cleared", 32'(pending), 0);
    count_door(n);
    check("single_dwell", 32'(n), 8);

    // Short glitch must not register
    btn[1] = 1'b1;
    repeat (3) tick();
    btn[1] = 1'b0;
    acc = '0;
    repeat (12) begin
      tick();
      acc = acc | pending | floor_req;
    end
    check("glitch_reject", 32'(acc), 0);

    // Dispatch down to 0, then async reset mid-dispatch
    btn[0] = 1'b1;
    repeat (7) tick();
    btn = '0;
    check("down_req", 32'(floor_req), 32'b0001);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_req", 32'(floor_req), 0);
    check("async_rst_pending", 32'(pending), 0);
    check("async_rst_out", 32'({door_open, serviced_valid, serviced_floor}), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // SCAN from floor 1 with direction reset to up
    current_floor = 1;
    btn = 4'b1001;
    repeat (7) tick();
    btn = '0;
    check("scan_first_req", 32'(floor_req), 32'b1000);
    check("scan_pending", 32'(pending), 32'b1001);
    sb.push_back(3);
    sb.push_back(0);
    current_floor = 3;
    tick();
    count_door(n);
    check("scan_dwell", 32'(n), 8);
    tick();
    check("scan_second_req", 32'(floor_req), 32'b0001);
    current_floor = 0;
    tick();
    count_door(n);
    check("scan_pending_done", 32'(pending), 0);

    // Emergency during dispatch, including arrival on an emergency cycle
    btn[2] = 1'b1;
    repeat (7) tick();
    btn = '0;
    check("emg_pre_req", 32'(floor_req), 32'b0100);
    emergency_stop = 1'b1;
    tick();
    check("emg_req", 32'(floor_req), 0);
    check("emg_pending", 32'(pending), 32'b0100);
    current_floor = 2;
    tick();
    check("emg_arrive_pending", 32'(pending), 32'b0100);
    check("emg_arrive_door", 32'(door_open), 0);
    current_floor = 0;
    tick();
    emergency_stop = 1'b0;
    tick();
    check("emg_release_req", 32'(floor_req), 0);
    tick();
    check("emg_reselect_req", 32'(floor_req), 32'b0100);
    sb.push_back(2);
    current_floor = 2;
    tick();
    count_door(n);
    check("emg_dwell", 32'(n), 8);

    // Same-floor press opens the door; a second press reloads the dwell
    current_floor = 1;
    btn[1] = 1'b1;
    repeat (5) tick();
    btn[1] = 1'b0;
    tick();
    check("same_door", 32'(door_open), 1);
    check("same_req", 32'(floor_req), 0);
    btn[1] = 1'b1;
    count_door(n);
    btn[1] = 1'b0;
    check("same_dwell_reload", 32'(n), 14);
    check("same_pending", 32'(pending), 0);

    // Randomized batches with a simple controller in the loop
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    model_up  = 1'b1;
    auto_ctrl = 1'b1;
    repeat (10) begin
      do begin
        calls = 4'($urandom_range(1, 15)) & ~(4'b0001 << current_floor);
      end while (calls == '0);
      push_scan(calls, int'(current_floor), model_up);
      btn = calls;
      repeat (7) tick();
      btn = '0;
      n = 0;
      while (!(sb.size() == 0 && door_open == 1'b0 && floor_req == '0) && n < 400) begin
        tick();
        n++;
      end
      check("batch_done_in_time", 32'(n < 400), 1);
      check("batch_pending_clear", 32'(pending), 0);
    end
    auto_ctrl = 1'b0;
    tick();
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
